// File: rtl/cell_cfg_loader.sv
// Serial configuration loader for the logic-cell array: assembles a parity-protected
// bitstream into a shadow register and commits it atomically to the parallel cell bus.
module cell_cfg_loader #(
   parameter int NCELLS = 8
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  sin,
   input  logic                  sin_valid,
   output logic                  sin_ready,
   output logic [NCELLS*8-1:0]   cfg_bus,
   output logic                  cfg_valid,
   output logic                  busy,
   output logic                  err
);

   localparam int PAYLOAD = NCELLS * 8;
   localparam int CW      = $clog2(PAYLOAD + 1);
   localparam int IW      = $clog2(PAYLOAD);
   localparam logic [CW-1:0] LAST_BIT = CW'(PAYLOAD - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      PAR  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 parity_q, parity_d;
   logic [PAYLOAD-1:0]   shadow_q, shadow_d;
   logic [PAYLOAD-1:0]   cfg_bus_q, cfg_bus_d;
   logic                 cfg_valid_q, cfg_valid_d;
   logic                 err_q, err_d;

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= IDLE;
         count_q     <= '0;
         parity_q    <= 1'b0;
         shadow_q    <= '0;
         cfg_bus_q   <= '0;
         cfg_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         parity_q    <= parity_d;
         shadow_q    <= shadow_d;
         cfg_bus_q   <= cfg_bus_d;
         cfg_valid_q <= cfg_valid_d;
         err_q       <= err_d;
      end
   end

   // abort outranks any transfer; cfg_valid is already low while a load is active
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      parity_d    = parity_q;
      shadow_d    = shadow_q;
      cfg_bus_d   = cfg_bus_q;
      cfg_valid_d = cfg_valid_q;
      err_d       = err_q;

      if (abort && state_q != IDLE) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d     = LOAD;
                  count_d     = '0;
                  parity_d    = 1'b0;
                  cfg_valid_d = 1'b0;
                  err_d       = 1'b0;
               end
            end
            LOAD: begin
               if (sin_valid) begin
                  shadow_d[count_q[IW-1:0]] = sin;
                  count_d  = count_q + CW'(1);
                  parity_d = parity_q ^ sin;
                  if (count_q == LAST_BIT) begin
                     state_d = PAR;
                  end
               end
            end
            PAR: begin
               if (sin_valid) begin
                  state_d = IDLE;
                  if ((parity_q ^ sin) == 1'b0) begin
                     cfg_bus_d   = shadow_q;
                     cfg_valid_d = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign sin_ready = (state_q == LOAD) || (state_q == PAR);
   assign busy      = (state_q == LOAD) || (state_q == PAR);
   assign cfg_bus   = cfg_bus_q;
   assign cfg_valid = cfg_valid_q;
   assign err       = err_q;

endmodule

// File: tb/tb_cell_cfg_loader.sv
// Directed, table-driven bench for cell_cfg_loader with NCELLS=2 (16-bit payload).
module tb_cell_cfg_loader;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        sin = 1'b0;
   logic        sin_valid = 1'b0;
   logic        sin_ready;
   logic [15:0] cfg_bus;
   logic        cfg_valid;
   logic        busy;
   logic        err;

   int checksTotal  = 0;
   int checksPassed = 0;
   bit busyDropped;

   typedef struct {
      logic [15:0] payload;
      logic        par;
      bit          gap;
      int          startAt;
      logic [15:0] expBus;
      logic        expValid;
      logic        expErr;
   } vec_t;

   vec_t vecs[8];

   cell_cfg_loader #(.NCELLS(2)) dut (
      .clk       (clk),
      .clr       (clr),
      .start     (start),
      .abort     (abort),
      .sin       (sin),
      .sin_valid (sin_valid),
      .sin_ready (sin_ready),
      .cfg_bus   (cfg_bus),
      .cfg_valid (cfg_valid),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checksTotal++;
      if (actual === expected) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Drives one start pulse followed by payload and parity bits. startAt/abortAt pick
   // a bit index at which start or abort is raised together with that bit.
   task automatic applyStimulus(input logic [15:0] payload, input logic par, input bit gap,
                                input int startAt, input int abortAt, input int nbits);
      logic [15:0] p;
      p = payload;
      busyDropped = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         sin       = (i < 16) ? p[i] : par;
         sin_valid = 1'b1;
         start     = (i == startAt);
         abort     = (i == abortAt);
         tick();
         start = 1'b0;
         abort = 1'b0;
         sin_valid = 1'b0;
         if (i == abortAt) break;
         if (i < 16 && busy !== 1'b1) busyDropped = 1'b1;
         if (gap && i < 16) begin
            tick();
            if (busy !== 1'b1) busyDropped = 1'b1;
         end
      end
   endtask

   initial begin
      vecs[0] = '{16'hA5C3, 1'b1, 1'b0, -1, 16'h0000, 1'b0, 1'b1};
      vecs[1] = '{16'hA5C3, 1'b0, 1'b0, -1, 16'hA5C3, 1'b1, 1'b0};
      vecs[2] = '{16'hA5C3, 1'b1, 1'b0, -1, 16'hA5C3, 1'b0, 1'b1};
      vecs[3] = '{16'h0F01, 1'b1, 1'b1, -1, 16'h0F01, 1'b1, 1'b0};
      vecs[4] = '{16'h0000, 1'b0, 1'b0, 16, 16'h0000, 1'b1, 1'b0};
      vecs[5] = '{16'h0001, 1'b0, 1'b0, -1, 16'h0000, 1'b0, 1'b1};
      vecs[6] = '{16'h1234, 1'b1, 1'b0, 7, 16'h1234, 1'b1, 1'b0};
      vecs[7] = '{16'h8000, 1'b1, 1'b1, -1, 16'h8000, 1'b1, 1'b0};

      tick();
      tick();
      clr = 1'b0;
      checkOutput("reset_bus", cfg_bus, 16'h0000);
      checkOutput("reset_valid", {15'd0, cfg_valid}, 16'd0);
      checkOutput("reset_err", {15'd0, err}, 16'd0);
      checkOutput("reset_busy", {15'd0, busy}, 16'd0);
      checkOutput("reset_ready", {15'd0, sin_ready}, 16'd0);

      // start latency: busy and sin_ready visible the cycle after start
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("start_busy", {15'd0, busy}, 16'd1);
      checkOutput("start_ready", {15'd0, sin_ready}, 16'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("abort_idle_busy", {15'd0, busy}, 16'd0);

      for (int v = 0; v < 8; v++) begin
         applyStimulus(vecs[v].payload, vecs[v].par, vecs[v].gap, vecs[v].startAt, -1, 17);
         checkOutput($sformatf("v%0d_bus", v), cfg_bus, vecs[v].expBus);
         checkOutput($sformatf("v%0d_valid", v), {15'd0, cfg_valid}, {15'd0, vecs[v].expValid});
         checkOutput($sformatf("v%0d_err", v), {15'd0, err}, {15'd0, vecs[v].expErr});
         checkOutput($sformatf("v%0d_busy", v), {15'd0, busy}, 16'd0);
         checkOutput($sformatf("v%0d_busy_during", v), {15'd0, busyDropped}, 16'd0);
      end

      // good load, then a FFFF load aborted after 5 bits, then a full FFFF load
      applyStimulus(16'hA5C3, 1'b0, 1'b0, -1, -1, 17);
      applyStimulus(16'hFFFF, 1'b0, 1'b0, -1, 5, 17);
      checkOutput("abort_busy", {15'd0, busy}, 16'd0);
      checkOutput("abort_ready", {15'd0, sin_ready}, 16'd0);
      checkOutput("abort_bus", cfg_bus, 16'hA5C3);
      checkOutput("abort_valid", {15'd0, cfg_valid}, 16'd0);
      checkOutput("abort_err", {15'd0, err}, 16'd0);
      applyStimulus(16'hFFFF, 1'b0, 1'b0, -1, -1, 17);
      checkOutput("reload_bus", cfg_bus, 16'hFFFF);
      checkOutput("reload_valid", {15'd0, cfg_valid}, 16'd1);

      // abort in IDLE leaves everything alone
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("idle_abort_bus", cfg_bus, 16'hFFFF);
      checkOutput("idle_abort_valid", {15'd0, cfg_valid}, 16'd1);
      checkOutput("idle_abort_busy", {15'd0, busy}, 16'd0);

      // abort coinciding with a correct parity bit: no commit, no err
      applyStimulus(16'h00F0, 1'b0, 1'b0, -1, 16, 17);
      checkOutput("abort_par_bus", cfg_bus, 16'hFFFF);
      checkOutput("abort_par_valid", {15'd0, cfg_valid}, 16'd0);
      checkOutput("abort_par_err", {15'd0, err}, 16'd0);
      checkOutput("abort_par_busy", {15'd0, busy}, 16'd0);

      // payload is held in the shadow until the parity bit commits it
      applyStimulus(16'h5555, 1'b0, 1'b0, -1, -1, 16);
      checkOutput("shadow_hidden_bus", cfg_bus, 16'hFFFF);
      checkOutput("shadow_hidden_busy", {15'd0, busy}, 16'd1);
      sin = 1'b0;
      sin_valid = 1'b1;
      tick();
      sin_valid = 1'b0;
      checkOutput("shadow_commit_bus", cfg_bus, 16'h5555);

      // clr mid-load with sin_valid and abort high forces reset values
      applyStimulus(16'hFFFF, 1'b0, 1'b0, -1, -1, 9);
      clr = 1'b1;
      sin = 1'b1;
      sin_valid = 1'b1;
      abort = 1'b1;
      tick();
      clr = 1'b0;
      sin_valid = 1'b0;
      abort = 1'b0;
      checkOutput("clr_bus", cfg_bus, 16'h0000);
      checkOutput("clr_valid", {15'd0, cfg_valid}, 16'd0);
      checkOutput("clr_err", {15'd0, err}, 16'd0);
      checkOutput("clr_busy", {15'd0, busy}, 16'd0);
      checkOutput("clr_ready", {15'd0, sin_ready}, 16'd0);

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
